// File: rtl/uart_pkg.sv
// Shared uart_core register map and TX scheduler state encoding.
package uart_pkg;

    localparam logic [11:0] ADDR_BAUD      = 12'h000;
    localparam logic [11:0] ADDR_TX_DATA   = 12'h004;
    localparam logic [11:0] ADDR_TX_LEVEL  = 12'h018;
    localparam logic [11:0] ADDR_RD_EN_TXF = 12'h01C;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOAD,
        LEVEL,
        START,
        STOP,
        WAIT
    } sched_state_e;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_core transmitter among NREQ byte streams by sequencing
// its TX registers directly; burst completion is purely timer-based.
module uart_tx_sched #(
    parameter int          NREQ       = 4,
    parameter int          BURST_MAX  = 7,
    parameter logic [15:0] BAUD_DIV   = 16'd868,
    parameter int          GUARD_BITS = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*8-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              reg_we_o,
    output logic [11:0]       reg_addr_o,
    output logic [31:0]       reg_wdata_o,
    output logic              reg_re_o,
    output logic [NREQ-1:0]   grant_o,
    output logic              busy_o,
    output logic              burst_done_o
);

    import uart_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_e    state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [23:0]     timer_q, timer_d;
    logic            we_q, we_d;
    logic [11:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic            acc;
    logic [7:0]      cur_byte;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Ready is the only path from requester inputs to outputs: it must
    // reflect same-cycle valid for the handshake to be lossless.
    always_comb begin
        acc         = (state_q == LOAD) && req_valid_i[gidx_q];
        req_ready_o = acc ? grant_q : '0;
        cur_byte    = req_data_i[int'(gidx_q)*8 +: 8];
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        we_d     = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
        done_d   = 1'b0;
        unique case (state_q)
            INIT: begin
                we_d    = 1'b1;
                addr_d  = ADDR_BAUD;
                wdata_d = {16'h0, BAUD_DIV};
                state_d = IDLE;
            end
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    if (int'(arb_idx) == NREQ - 1) rr_ptr_d = '0;
                    else rr_ptr_d = arb_idx + 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (acc) begin
                    we_d    = 1'b1;
                    addr_d  = ADDR_TX_DATA;
                    wdata_d = {24'h0, cur_byte};
                    cnt_d   = cnt_q + 3'd1;
                    if (req_last_i[gidx_q] ||
                        (4'(cnt_q) + 4'd1 == 4'(BURST_MAX)))
                        state_d = LEVEL;
                end else if (cnt_q != 3'd0) begin
                    state_d = LEVEL;
                end
            end
            LEVEL: begin
                we_d    = 1'b1;
                addr_d  = ADDR_TX_LEVEL;
                wdata_d = {29'h0, cnt_q};
                state_d = START;
            end
            START: begin
                we_d    = 1'b1;
                addr_d  = ADDR_RD_EN_TXF;
                wdata_d = 32'd1;
                state_d = STOP;
            end
            STOP: begin
                we_d    = 1'b1;
                addr_d  = ADDR_RD_EN_TXF;
                wdata_d = 32'd0;
                timer_d = (24'(cnt_q) * 24'd10 + 24'(GUARD_BITS))
                          * 24'(BAUD_DIV);
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q - 24'd1;
                if (timer_q <= 24'd1) begin
                    timer_d = '0;
                    done_d  = 1'b1;
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= INIT;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign reg_we_o     = we_q;
    assign reg_addr_o   = addr_q;
    assign reg_wdata_o  = wdata_q;
    assign reg_re_o     = 1'b0;
    assign grant_o      = grant_q;
    assign busy_o       = busy_q;
    assign burst_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: logs register writes, grants and
// done pulses, then checks them against hand-computed sequences.
module tb_uart_tx_sched;

    localparam int          NREQ  = 4;
    localparam logic [15:0] BAUD  = 16'd5;
    localparam int          GUARD = 2;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*8-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic              reg_we;
    logic [11:0]       reg_addr;
    logic [31:0]       reg_wdata;
    logic              reg_re;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              done;

    uart_tx_sched #(
        .NREQ       (NREQ),
        .BURST_MAX  (7),
        .BAUD_DIV   (BAUD),
        .GUARD_BITS (GUARD)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_last_i   (req_last),
        .req_ready_o  (req_ready),
        .reg_we_o     (reg_we),
        .reg_addr_o   (reg_addr),
        .reg_wdata_o  (reg_wdata),
        .reg_re_o     (reg_re),
        .grant_o      (grant),
        .busy_o       (busy),
        .burst_done_o (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } byte_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    byte_t     rq[NREQ][$];
    wr_t       wq[$];
    int        dq[$];
    int        gq[$];
    int        cyc = 0;
    int        vectors = 0;
    int        errors = 0;
    logic [NREQ-1:0] acc_m = '0;
    logic [NREQ-1:0] grant_prev = '0;

    always @(posedge clk) begin
        cyc++;
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_m[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            req_valid[i] = (rq[i].size() > 0);
            req_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0].data : 8'h00;
            req_last[i] = (rq[i].size() > 0) ? rq[i][0].last : 1'b0;
        end
        acc_m = '0;
    end

    always @(negedge clk) begin
        acc_m = req_valid & req_ready;
        if (reg_we) begin
            wq.push_back('{addr: reg_addr, data: reg_wdata, cyc: cyc});
        end else if (rst_ni) begin
            vectors++;
            assert (reg_addr === 12'h0 && reg_wdata === 32'h0) else begin
                errors++;
                $error("FAIL idle_bus: addr=%h data=%h expected 0/0",
                       reg_addr, reg_wdata);
            end
        end
        if (done) dq.push_back(cyc);
        if (grant != '0 && grant_prev == '0) begin
            for (int i = 0; i < NREQ; i++) if (grant[i]) gq.push_back(i);
        end
        grant_prev = grant;
    end

    task automatic exp_wr(input string tag, input logic [11:0] a,
                          input logic [31:0] d, output int c);
        int n = 0;
        wr_t e;
        c = 0;
        while (wq.size() == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        assert (wq.size() != 0) else begin
            errors++;
            $error("FAIL %s: no write seen, expected %h=%h", tag, a, d);
        end
        if (wq.size() != 0) begin
            e = wq.pop_front();
            c = e.cyc;
            assert (e.addr === a && e.data === d) else begin
                errors++;
                $error("FAIL %s: got %h=%h expected %h=%h",
                       tag, e.addr, e.data, a, d);
            end
        end
    endtask

    task automatic exp_burst(input string tag, input logic [7:0] first,
                             input int n, input logic [7:0] nxt);
        int c;
        int n_done = 0;
        int got;
        for (int i = 0; i < n; i++) begin
            exp_wr(tag, 12'h004, {24'h0, (i == 0) ? first : nxt + 8'(i - 1)}, c);
        end
        exp_wr(tag, 12'h018, 32'(n), c);
        exp_wr(tag, 12'h01C, 32'd1, c);
        exp_wr(tag, 12'h01C, 32'd0, c);
        while (dq.size() == 0 && n_done < 2000) begin
            @(negedge clk);
            n_done++;
        end
        got = (dq.size() != 0) ? dq.pop_front() - c : -1;
        vectors++;
        assert (got === (n * 10 + GUARD) * int'(BAUD)) else begin
            errors++;
            $error("FAIL %s_wait: got %0d cycles expected %0d",
                   tag, got, (n * 10 + GUARD) * int'(BAUD));
        end
    endtask

    task automatic exp_grant(input string tag, input int g);
        int got;
        got = (gq.size() != 0) ? gq.pop_front() : -1;
        vectors++;
        assert (got === g) else begin
            errors++;
            $error("FAIL %s: grant %0d expected %0d", tag, got, g);
        end
    endtask

    task automatic exp_quiet(input string tag);
        repeat (5) @(negedge clk);
        vectors++;
        assert (wq.size() == 0 && busy === 1'b0) else begin
            errors++;
            $error("FAIL %s: extra writes %0d busy %b expected 0/0",
                   tag, wq.size(), busy);
        end
    endtask

    task automatic exp_rst_outputs(input string tag);
        vectors++;
        assert ({reg_we, reg_addr, reg_wdata, reg_re, grant, busy, done,
                 req_ready} === '0) else begin
            errors++;
            $error("FAIL %s: we=%b addr=%h wd=%h g=%b busy=%b done=%b rdy=%b expected all 0",
                   tag, reg_we, reg_addr, reg_wdata, grant, busy, done, req_ready);
        end
    endtask

    initial begin
        int c;
        int n;

        repeat (3) @(negedge clk);
        exp_rst_outputs("reset_outputs");
        rst_ni = 1'b1;
        exp_wr("init_baud", 12'h000, 32'd5, c);
        exp_quiet("init_idle");

        // Round-robin: two 1-byte messages per requester.
        for (int r = 0; r < NREQ; r++) begin
            rq[r].push_back('{last: 1'b1, data: 8'h10 + 8'(r)});
            rq[r].push_back('{last: 1'b1, data: 8'h20 + 8'(r)});
        end
        for (int k = 0; k < 2 * NREQ; k++) begin
            exp_burst("rr", (k < NREQ) ? 8'h10 + 8'(k) : 8'h20 + 8'(k - NREQ),
                      1, 8'h00);
        end
        exp_grant("rr_g0", 0);
        exp_grant("rr_g1", 1);
        exp_grant("rr_g2", 2);
        exp_grant("rr_g3", 3);
        exp_grant("rr_g4", 0);
        gq.delete();
        exp_quiet("rr_idle");

        // Single 3-byte message.
        rq[0].push_back('{last: 1'b0, data: 8'h41});
        rq[0].push_back('{last: 1'b0, data: 8'h42});
        rq[0].push_back('{last: 1'b1, data: 8'h43});
        exp_burst("msg3", 8'h41, 3, 8'h42);
        exp_grant("msg3_g", 0);
        exp_quiet("msg3_idle");

        // Burst limit: 10 bytes split 7 + 3.
        for (int i = 0; i < 10; i++) begin
            rq[1].push_back('{last: (i == 9), data: 8'h50 + 8'(i)});
        end
        exp_burst("lim7", 8'h50, 7, 8'h51);
        exp_burst("lim3", 8'h57, 3, 8'h58);
        exp_grant("lim_g0", 1);
        exp_grant("lim_g1", 1);
        exp_quiet("lim_idle");

        // Valid gap: two bytes without last.
        rq[2].push_back('{last: 1'b0, data: 8'h60});
        rq[2].push_back('{last: 1'b0, data: 8'h61});
        exp_burst("gap", 8'h60, 2, 8'h61);
        exp_grant("gap_g", 2);
        exp_quiet("gap_idle");

        // Mid-burst reset.
        for (int i = 0; i < 5; i++) begin
            rq[3].push_back('{last: (i == 4), data: 8'h70 + 8'(i)});
        end
        n = 0;
        while (!(reg_we && reg_addr == 12'h004) && n < 500) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        assert (n < 500) else begin
            errors++;
            $error("FAIL mrst_load: no TX_DATA write within %0d cycles", n);
        end
        rst_ni = 1'b0;
        #1;
        exp_rst_outputs("mrst_outputs");
        rq[3].delete();
        repeat (3) @(negedge clk);
        wq.delete();
        dq.delete();
        gq.delete();
        rst_ni = 1'b1;
        exp_wr("mrst_init", 12'h000, 32'd5, c);
        exp_quiet("mrst_idle");
        vectors++;
        assert (dq.size() == 0 && gq.size() == 0) else begin
            errors++;
            $error("FAIL mrst_nodone: done=%0d grants=%0d expected 0/0",
                   dq.size(), gq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
